// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: pops one byte per tx_start/tx_done handshake.
// Write to tx_start is 2 cycles; writes to a full FIFO are dropped and flagged sticky.
module uart_tx_fifo #(
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              flush,
   input  logic              clr_err,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic [31:0]       tx_data,
   output logic              tx_start,
   input  logic              tx_done,
   output logic              busy,
   output logic              overflow,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   localparam int              LVL_W     = ADDR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT_CYC - 1);

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [15:0]       wait_cnt;
   state_t            state;
   logic              accept;
   logic              drop;
   logic              pop;
   logic              to_hit;

   // full uses the registered level, so a same-cycle pop never frees a slot
   assign full   = (level == FULL_LVL);
   assign empty  = (level == '0);
   assign busy   = (state != IDLE);
   assign accept = wr_en && !full && !flush;
   assign drop   = wr_en && full && !flush;
   assign pop    = (state == IDLE) && !empty && !flush;
   assign to_hit = (state == WAIT) && !tx_done && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         state       <= IDLE;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (accept) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + ADDR_W'(1);
            level <= level + LVL_W'(accept) - LVL_W'(pop);
         end

         // set events take precedence over clr_err
         if (drop)         overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;

         if (to_hit)       timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;

         // a pop always moves IDLE -> START, so this is the START-cycle decode
         tx_start <= pop;

         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= {24'd0, mem[rd_ptr]};
                  state   <= START;
               end
            end
            START: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (tx_done || to_hit) state <= IDLE;
               else                   wait_cnt <= wait_cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
